sequential_shifter_left_logical: RTL and testbench

//  Multi-cycle left logical shifter (SLL/SLLI) for the RISC-V datapath. It is the left-direction

---
 rtl/sequential_shifter_left_logical.sv | 98 +++++++++
 tb/tb_sequential_shifter_left_logical.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sequential_shifter_left_logical.sv
// Multi-cycle left logical shifter: one binary stage (shift by 2^k) per clock,
// fixed latency, start/busy/done handshake, result held until the next accepted start.
module sequential_shifter_left_logical #(
   parameter int unsigned nb_bits_data  = 32,
   parameter int unsigned nb_bits_shift = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [nb_bits_data-1:0]  data_i,
   input  logic [nb_bits_shift-1:0] shamt_i,
   output logic [nb_bits_data-1:0]  data_o,
   output logic                     busy_o,
   output logic                     done_o
);

   localparam int unsigned CntW = (nb_bits_shift > 1) ? $clog2(nb_bits_shift) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(nb_bits_shift - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e                   state_q, state_d;
   logic [nb_bits_data-1:0]  work_q, work_d;
   logic [nb_bits_shift-1:0] shamt_q, shamt_d;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     accept;

   logic [nb_bits_data-1:0]  stage_out [nb_bits_shift];
   logic [nb_bits_data-1:0]  stage_sel;

   // Fixed per-stage shifters; stage k moves the word by 2^k when enabled.
   for (genvar k = 0; k < nb_bits_shift; k++) begin : g_stage
      assign stage_out[k] = shamt_q[k] ? (work_q << (2 ** k)) : work_q;
   end

   always_comb begin
      stage_sel = work_q;
      for (int k = 0; k < nb_bits_shift; k++) begin
         if (cnt_q == CntW'(k)) stage_sel = stage_out[k];
      end
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      shamt_d = shamt_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: accept = start_i;
         StShift: begin
            work_d = stage_sel;
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntLast) state_d = StDone;
         end
         // The edge that leaves DONE also samples start, so held-high start
         // gives one operation every nb_bits_shift+1 cycles.
         StDone: begin
            state_d = StIdle;
            accept  = start_i;
         end
         default: state_d = StIdle;
      endcase
      if (accept) begin
         state_d = StShift;
         work_d  = data_i;
         shamt_d = shamt_i;
         cnt_d   = '0;
      end
      busy_d = (state_d == StShift);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         work_q  <= '0;
         shamt_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         shamt_q <= shamt_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign data_o = work_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_sequential_shifter_left_logical.sv
// Self-checking bench for sequential_shifter_left_logical: directed table,
// back-to-back held start, mid-shift reset and a randomised model comparison.
module tb_sequential_shifter_left_logical;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] data = '0;
   logic [4:0]  shamt = '0;
   logic [31:0] data_o;
   logic        busy_o;
   logic        done_o;

   int checks = 0;
   int errors = 0;

   sequential_shifter_left_logical #(
      .nb_bits_data  (32),
      .nb_bits_shift (5)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .data_i  (data),
      .shamt_i (shamt),
      .data_o  (data_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  s;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [9];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and check busy/done timing, result and hold.
   task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [31:0] exp,
                         input int gap);
      @(negedge clk);
      start = 1'b1;
      data  = d;
      shamt = s;
      tick();
      start = 1'b0;
      data  = $urandom;
      shamt = 5'($urandom);
      for (int i = 0; i < 5; i++) begin
         chk("busy_in_shift", {62'd0, busy_o, done_o}, 64'd2);
         tick();
      end
      chk("done_pulse", {62'd0, busy_o, done_o}, 64'd1);
      chk("result", {32'd0, data_o}, {32'd0, exp});
      tick();
      chk("after_done", {62'd0, busy_o, done_o}, 64'd0);
      chk("hold", {32'd0, data_o}, {32'd0, exp});
      for (int i = 0; i < gap; i++) begin
         tick();
         chk("idle_hold", {30'd0, busy_o, done_o, data_o}, {32'd0, exp});
      end
   endtask

   logic [31:0] hd [18];
   logic [4:0]  hs [18];
   logic [31:0] rd;
   logic [4:0]  rs;
   int          done_seen;

   initial begin
      vecs[0] = '{32'h00000001, 5'd31, 32'h80000000};
      vecs[1] = '{32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
      vecs[2] = '{32'hFFFFFFFF, 5'd4,  32'hFFFFFFF0};
      vecs[3] = '{32'h12345678, 5'd8,  32'h34567800};
      vecs[4] = '{32'h80000001, 5'd1,  32'h00000002};
      vecs[5] = '{32'hA5A5A5A5, 5'd16, 32'hA5A50000};
      vecs[6] = '{32'h00000003, 5'd2,  32'h0000000C};
      vecs[7] = '{32'hF0F0F0F0, 5'd31, 32'h00000000};
      vecs[8] = '{32'h0000FFFF, 5'd17, 32'hFFFE0000};

      tick();
      tick();
      chk("reset_outputs", {30'd0, busy_o, done_o, data_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_op(vecs[i].d, vecs[i].s, vecs[i].exp, 2);

      // Held start with operands changing every cycle: accepts at E, E+6, E+12.
      for (int c = 0; c < 18; c++) begin
         hd[c] = $urandom;
         hs[c] = 5'($urandom);
      end
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         start = 1'b1;
         data  = hd[c];
         shamt = hs[c];
         tick();
         if ((c % 6) == 5) begin
            chk("b2b_done", {62'd0, busy_o, done_o}, 64'd1);
            chk("b2b_result", {32'd0, data_o}, {32'd0, hd[c-5] << hs[c-5]});
         end else begin
            chk("b2b_busy", {62'd0, busy_o, done_o}, 64'd2);
         end
      end
      @(negedge clk);
      start = 1'b0;
      tick();
      chk("b2b_idle", {62'd0, busy_o, done_o}, 64'd0);

      // Reset during the third SHIFT cycle discards the operation.
      @(negedge clk);
      start = 1'b1;
      data  = 32'h0000FFFF;
      shamt = 5'd3;
      tick();
      start = 1'b0;
      tick();
      tick();
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("midreset_clear", {30'd0, busy_o, done_o, data_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done_o) done_seen++;
      end
      chk("midreset_no_done", 64'(done_seen), 64'd0);
      run_op(32'h3, 5'd2, 32'hC, 1);

      for (int n = 0; n < 3000; n++) begin
         rd = $urandom;
         rs = 5'($urandom);
         run_op(rd, rs, rd << rs, int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
